// File: rtl/udp_pkg.sv
// Shared types and widths for the UDP loopback buffer.
package udp_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StSend,
    StWait
  } rd_state_e;

endpackage

// File: rtl/udp_buf_ram.sv
// Simple dual-port payload RAM: one write port, one registered read port.
module udp_buf_ram
  import udp_pkg::*;
#(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [BYTE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [BYTE_W-1:0] o_rdata
);

  logic [BYTE_W-1:0] r_mem [2**ADDR_W];
  logic [BYTE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register holds its value when not enabled so tx_data stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/udp_loop_buf.sv
// Loopback payload buffer: stores validated UDP payloads and replays them to the transmitter.
module udp_loop_buf
  import udp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned LEN_DEPTH_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_en,
  input  logic [BYTE_W-1:0] rec_data,
  input  logic              rec_pkt_done,
  input  logic [LEN_W-1:0]  rec_byte_num,
  input  logic              tx_busy,
  input  logic              tx_req,
  input  logic              tx_done,
  output logic              tx_start_en,
  output logic [LEN_W-1:0]  tx_byte_num,
  output logic [BYTE_W-1:0] tx_data,
  output logic              pkt_pending,
  output logic [LEN_W-1:0]  drop_cnt
);

  localparam int unsigned DescDepth = 2**LEN_DEPTH_W;
  localparam logic [ADDR_W:0]      FullUsed = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]      PtrOne   = (ADDR_W+1)'(1);
  localparam logic [LEN_DEPTH_W:0] DescFull = (LEN_DEPTH_W+1)'(DescDepth);
  localparam logic [LEN_DEPTH_W:0] DescOne  = (LEN_DEPTH_W+1)'(1);

  logic [ADDR_W:0]      r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [LEN_W-1:0]     r_pkt_cnt, r_sent, r_drop_cnt, r_tx_byte_num;
  logic                 r_ovf, r_tx_start_en, r_pkt_pending;
  rd_state_e            r_state;

  logic [LEN_W-1:0]       r_desc_mem [DescDepth];
  logic [LEN_DEPTH_W-1:0] r_desc_wp, r_desc_rp;
  logic [LEN_DEPTH_W:0]   r_desc_cnt;

  logic [ADDR_W:0]      w_used, w_wr_ptr_nxt;
  logic                 w_full, w_wr, w_ovf_final, w_fifo_full, w_drop, w_push, w_pop, w_rd_en;
  logic [LEN_W-1:0]     w_cnt_final, w_sent_inc;
  logic [LEN_DEPTH_W:0] w_desc_cnt_nxt;

  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_used == FullUsed);
  assign w_wr         = rec_en & ~w_full;
  assign w_wr_ptr_nxt = w_wr ? r_wr_ptr + PtrOne : r_wr_ptr;
  assign w_cnt_final  = w_wr ? r_pkt_cnt + 16'd1 : r_pkt_cnt;
  assign w_ovf_final  = r_ovf | (rec_en & w_full);
  assign w_fifo_full  = (r_desc_cnt == DescFull);
  assign w_drop       = w_ovf_final | w_fifo_full | (rec_byte_num == '0) |
                        (rec_byte_num != w_cnt_final);
  assign w_push       = rec_pkt_done & ~w_drop;
  assign w_pop        = (r_state == StIdle) & (r_desc_cnt != '0) & ~tx_busy;
  assign w_rd_en      = (r_state == StSend) & tx_req;
  assign w_sent_inc   = r_sent + 16'd1;

  always_comb begin
    w_desc_cnt_nxt = r_desc_cnt;
    if (w_push && !w_pop) w_desc_cnt_nxt = r_desc_cnt + DescOne;
    else if (!w_push && w_pop) w_desc_cnt_nxt = r_desc_cnt - DescOne;
  end

  udp_buf_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (rec_data),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (tx_data)
  );

  // Write side: bytes become visible to the reader only once committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkt_cnt    <= '0;
      r_ovf        <= 1'b0;
      r_drop_cnt   <= '0;
    end else if (rec_pkt_done) begin
      r_pkt_cnt <= '0;
      r_ovf     <= 1'b0;
      if (w_drop) begin
        r_wr_ptr <= r_commit_ptr;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end else begin
        r_wr_ptr     <= w_wr_ptr_nxt;
        r_commit_ptr <= w_wr_ptr_nxt;
      end
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_pkt_cnt <= w_cnt_final;
      r_ovf     <= w_ovf_final;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_desc_mem[r_desc_wp] <= rec_byte_num;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_desc_wp     <= '0;
      r_desc_rp     <= '0;
      r_desc_cnt    <= '0;
      r_pkt_pending <= 1'b0;
    end else begin
      if (w_push) r_desc_wp <= r_desc_wp + 1'b1;
      if (w_pop)  r_desc_rp <= r_desc_rp + 1'b1;
      r_desc_cnt    <= w_desc_cnt_nxt;
      r_pkt_pending <= (w_desc_cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_tx_start_en <= 1'b0;
      r_tx_byte_num <= '0;
      r_rd_ptr      <= '0;
      r_sent        <= '0;
    end else begin
      r_tx_start_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_tx_byte_num <= r_desc_mem[r_desc_rp];
            r_tx_start_en <= 1'b1;
            r_state       <= StStart;
          end
        end
        StStart: r_state <= StSend;
        StSend: begin
          if (tx_req) begin
            r_rd_ptr <= r_rd_ptr + PtrOne;
            r_sent   <= w_sent_inc;
            if (w_sent_inc == r_tx_byte_num) r_state <= StWait;
          end
        end
        StWait: begin
          if (tx_done) begin
            r_sent  <= '0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign tx_start_en = r_tx_start_en;
  assign tx_byte_num = r_tx_byte_num;
  assign pkt_pending = r_pkt_pending;
  assign drop_cnt    = r_drop_cnt;

endmodule
